// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory access controller.
package mem_access_ctrl_pkg;

  localparam int DATA_W      = 16;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } mac_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Saturating 8-bit WAIT-cycle counter with clear/enable and a terminal-count flag.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // The request cycle is the first stall cycle, so the last WAIT cycle is the one at count TIMEOUT-2.
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q >= TC_VAL);

endmodule

// File: rtl/reg1.sv
// 1-bit enabled register cell with asynchronous active-low reset.
module reg1 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg16.sv
// 16-bit enabled register cell with asynchronous active-low reset.
module reg16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one data memory access per instruction, stalls the
// upstream pipeline while memory is busy, and captures load data / errors for MEM/WB.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_EXMEM,
  input  logic              MemWrite_EXMEM,
  input  logic [DATA_W-1:0] ALU_Out_EXMEM,
  input  logic [DATA_W-1:0] read2Data_EXMEM,
  input  logic              err_decode_EXMEM,
  input  logic              inst_mem_err_EXMEM,
  input  logic              Halt_EXMEM,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              stall_pipe,
  output logic [DATA_W-1:0] MemOut_MEM,
  output logic              mem_err_MEM
);

  mac_state_e        state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic              access, issue, stall;
  logic              lat_we, out_we, err_we, err_d;
  logic              cnt_clr, cnt_en, tc;
  logic [DATA_W-1:0] addr_q, wdata_q;

  always_comb begin
    // Errored and HALT instructions never reach memory; read wins if both flags are set.
    access  = (MemRead_EXMEM | MemWrite_EXMEM) & ~err_decode_EXMEM &
              ~inst_mem_err_EXMEM & ~Halt_EXMEM;
    state_d = state_q;
    is_rd_d = is_rd_q;
    issue   = 1'b0;
    stall   = 1'b0;
    lat_we  = 1'b0;
    out_we  = 1'b0;
    err_we  = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (mem_stall) begin
            stall = 1'b1;
          end else begin
            issue   = 1'b1;
            lat_we  = 1'b1;
            is_rd_d = MemRead_EXMEM;
            if (mem_done) begin
              out_we = MemRead_EXMEM;
              err_we = 1'b1;
              err_d  = mem_err;
            end else begin
              stall   = 1'b1;
              cnt_clr = 1'b1;
              state_d = WAIT;
            end
          end
        end else begin
          err_we = 1'b1;
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (mem_done) begin
          out_we  = is_rd_q;
          err_we  = 1'b1;
          err_d   = mem_err;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (tc) begin
            err_we  = 1'b1;
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are combinational, so keep them quiet while reset is held even if EX/MEM shows an access.
    if (!rst) begin
      issue = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
    end
  end

  mem_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  reg16 u_addr  (.clk(clk), .rst_n(rst), .en(lat_we), .d(ALU_Out_EXMEM),   .q(addr_q));
  reg16 u_wdata (.clk(clk), .rst_n(rst), .en(lat_we), .d(read2Data_EXMEM), .q(wdata_q));
  reg16 u_out   (.clk(clk), .rst_n(rst), .en(out_we), .d(mem_rdata),       .q(MemOut_MEM));
  reg1  u_err   (.clk(clk), .rst_n(rst), .en(err_we), .d(err_d),           .q(mem_err_MEM));

  assign mem_rd     = issue & MemRead_EXMEM;
  assign mem_wr     = issue & ~MemRead_EXMEM;
  assign mem_addr   = issue ? ALU_Out_EXMEM   : addr_q;
  assign mem_wdata  = issue ? read2Data_EXMEM : wdata_q;
  assign stall_pipe = stall;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, corner sequences, random transactions.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_EXMEM, MemWrite_EXMEM, err_decode_EXMEM, inst_mem_err_EXMEM, Halt_EXMEM;
  logic [15:0] ALU_Out_EXMEM, read2Data_EXMEM;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, MemOut_MEM;
  logic        mem_rd, mem_wr, mem_stall, mem_done, mem_err, stall_pipe, mem_err_MEM;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst                (rst),
    .MemRead_EXMEM      (MemRead_EXMEM),
    .MemWrite_EXMEM     (MemWrite_EXMEM),
    .ALU_Out_EXMEM      (ALU_Out_EXMEM),
    .read2Data_EXMEM    (read2Data_EXMEM),
    .err_decode_EXMEM   (err_decode_EXMEM),
    .inst_mem_err_EXMEM (inst_mem_err_EXMEM),
    .Halt_EXMEM         (Halt_EXMEM),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rd             (mem_rd),
    .mem_wr             (mem_wr),
    .mem_stall          (mem_stall),
    .mem_done           (mem_done),
    .mem_rdata          (mem_rdata),
    .mem_err            (mem_err),
    .stall_pipe         (stall_pipe),
    .MemOut_MEM         (MemOut_MEM),
    .mem_err_MEM        (mem_err_MEM)
  );

  // ctl = {rd, wr, dec_err, fetch_err, halt, mem_stall, mem_done, mem_err}; ef = {rd, wr, stall}
  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] addr, wdata, rdata;
    logic [2:0]  ef;
    logic [15:0] e_addr, e_wdata, e_out;
    logic        e_err;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic rd, input logic wr, input logic dec, input logic ime,
                          input logic halt, input logic [15:0] a, input logic [15:0] w);
    MemRead_EXMEM      = rd;
    MemWrite_EXMEM     = wr;
    err_decode_EXMEM   = dec;
    inst_mem_err_EXMEM = ime;
    Halt_EXMEM         = halt;
    ALU_Out_EXMEM      = a;
    read2Data_EXMEM    = w;
  endtask

  task automatic set_mem(input logic st, input logic dn, input logic [15:0] rdat, input logic er);
    mem_stall = st;
    mem_done  = dn;
    mem_rdata = rdat;
    mem_err   = er;
  endtask

  initial begin
    int          rd_cnt, wr_cnt, st_cnt;
    logic        found;
    logic [15:0] prev_out;

    vt[0]  = '{8'b1000_0010, 16'h0040, 16'h0000, 16'hBEEF, 3'b100, 16'h0040, 16'h0000, 16'hBEEF, 1'b0};
    vt[1]  = '{8'b0100_0010, 16'h0102, 16'h1234, 16'h5555, 3'b010, 16'h0102, 16'h1234, 16'hBEEF, 1'b0};
    // Read and write both set is a decoder bug upstream; the controller treats it as a read.
    vt[2]  = '{8'b1100_0010, 16'h0200, 16'h0F0F, 16'h0A0A, 3'b100, 16'h0200, 16'h0F0F, 16'h0A0A, 1'b0};
    vt[3]  = '{8'b1000_0011, 16'h0300, 16'h0000, 16'h7777, 3'b100, 16'h0300, 16'h0000, 16'h7777, 1'b1};
    vt[4]  = '{8'b0000_0011, 16'h0000, 16'h0000, 16'h9999, 3'b000, 16'h0300, 16'h0000, 16'h7777, 1'b0};
    vt[5]  = '{8'b0110_0010, 16'h0400, 16'h5A5A, 16'h3333, 3'b000, 16'h0300, 16'h0000, 16'h7777, 1'b0};
    vt[6]  = '{8'b1000_1010, 16'h0410, 16'h0000, 16'h1111, 3'b000, 16'h0300, 16'h0000, 16'h7777, 1'b0};
    vt[7]  = '{8'b1001_0010, 16'h0420, 16'h0000, 16'h2222, 3'b000, 16'h0300, 16'h0000, 16'h7777, 1'b0};
    vt[8]  = '{8'b1000_0100, 16'h0430, 16'h0000, 16'h0000, 3'b001, 16'h0300, 16'h0000, 16'h7777, 1'b0};
    vt[9]  = '{8'b1000_0110, 16'h0440, 16'h0000, 16'h2222, 3'b001, 16'h0300, 16'h0000, 16'h7777, 1'b0};
    vt[10] = '{8'b0100_0011, 16'h0500, 16'hABCD, 16'h6666, 3'b010, 16'h0500, 16'hABCD, 16'h7777, 1'b1};
    vt[11] = '{8'b0100_0100, 16'h0510, 16'h1111, 16'h0000, 3'b001, 16'h0500, 16'hABCD, 16'h7777, 1'b1};
    vt[12] = '{8'b1000_0010, 16'h0600, 16'h0000, 16'h4242, 3'b100, 16'h0600, 16'h0000, 16'h4242, 1'b0};

    // Reset with a ready load presented: nothing may be issued or stalled.
    rst = 1'b0;
    set_inst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
    set_mem(1'b0, 1'b0, 16'h0000, 1'b0);
    #12;
    chk("rst.mem_rd", mem_rd, 0);
    chk("rst.mem_wr", mem_wr, 0);
    chk("rst.mem_addr", mem_addr, 16'h0000);
    chk("rst.mem_wdata", mem_wdata, 16'h0000);
    chk("rst.stall_pipe", stall_pipe, 0);
    chk("rst.MemOut_MEM", MemOut_MEM, 16'h0000);
    chk("rst.mem_err_MEM", mem_err_MEM, 0);
    set_inst(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      {MemRead_EXMEM, MemWrite_EXMEM, err_decode_EXMEM, inst_mem_err_EXMEM, Halt_EXMEM,
       mem_stall, mem_done, mem_err} = vt[i].ctl;
      ALU_Out_EXMEM   = vt[i].addr;
      read2Data_EXMEM = vt[i].wdata;
      mem_rdata       = vt[i].rdata;
      #1;
      chk($sformatf("v%0d.mem_rd", i), mem_rd, vt[i].ef[2]);
      chk($sformatf("v%0d.mem_wr", i), mem_wr, vt[i].ef[1]);
      chk($sformatf("v%0d.stall", i), stall_pipe, vt[i].ef[0]);
      chk($sformatf("v%0d.addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d.wdata", i), mem_wdata, vt[i].e_wdata);
      tick();
      chk($sformatf("v%0d.MemOut", i), MemOut_MEM, vt[i].e_out);
      chk($sformatf("v%0d.err", i), mem_err_MEM, vt[i].e_err);
    end
    set_inst(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_mem(1'b0, 1'b0, 16'h0000, 1'b0);

    // Store miss: done three cycles after the request.
    set_inst(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, 16'h1234);
    set_mem(1'b0, 1'b0, 16'hAAAA, 1'b0);
    rd_cnt = 0; wr_cnt = 0; st_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      mem_done = (c == 3);
      #1;
      rd_cnt += int'(mem_rd);
      wr_cnt += int'(mem_wr);
      st_cnt += int'(stall_pipe);
      if (c == 1) begin
        chk("smiss.hold_addr", mem_addr, 16'h0102);
        chk("smiss.hold_wdata", mem_wdata, 16'h1234);
      end
      if (c == 3) chk("smiss.release", stall_pipe, 0);
      tick();
    end
    chk("smiss.wr_pulses", wr_cnt, 1);
    chk("smiss.rd_pulses", rd_cnt, 0);
    chk("smiss.stall_cycles", st_cnt, 3);
    chk("smiss.MemOut", MemOut_MEM, 16'h4242);
    chk("smiss.err", mem_err_MEM, 0);

    // Busy memory for two cycles, then a one-cycle miss.
    set_inst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0000);
    set_mem(1'b1, 1'b0, 16'h1357, 1'b0);
    rd_cnt = 0; st_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      mem_stall = (c < 2);
      mem_done  = (c == 3);
      #1;
      if (c < 2) chk($sformatf("busy.no_req%0d", c), mem_rd, 0);
      rd_cnt += int'(mem_rd);
      st_cnt += int'(stall_pipe);
      tick();
    end
    chk("busy.rd_pulses", rd_cnt, 1);
    chk("busy.stall_cycles", st_cnt, 3);
    chk("busy.MemOut", MemOut_MEM, 16'h1357);

    // Timeout: memory never answers, then a late done arrives during DRAIN.
    set_inst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000);
    set_mem(1'b0, 1'b0, 16'hC0DE, 1'b0);
    rd_cnt = 0; st_cnt = 0; found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      rd_cnt += int'(mem_rd);
      if (!stall_pipe) begin
        found = 1'b1;
        break;
      end
      st_cnt++;
      tick();
    end
    chk("tmo.released", found, 1);
    chk("tmo.stall_cycles", st_cnt, TO);
    chk("tmo.rd_pulses", rd_cnt, 1);
    chk("tmo.err_set", mem_err_MEM, 1);
    mem_done = 1'b1;
    #1;
    chk("tmo.drain_no_req", mem_rd, 0);
    tick();
    set_inst(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    mem_done = 1'b0;
    #1;
    chk("tmo.no_reissue", mem_rd, 0);
    chk("tmo.late_done_ignored", MemOut_MEM, 16'h1357);
    chk("tmo.err_held", mem_err_MEM, 1);
    tick();
    chk("tmo.err_cleared", mem_err_MEM, 0);

    // Asynchronous reset in the middle of a miss.
    set_inst(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0900, 16'h0000);
    set_mem(1'b0, 1'b0, 16'hD00D, 1'b1);
    #1;
    chk("rwait.stall", stall_pipe, 1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rwait.stall", stall_pipe, 0);
    chk("rwait.mem_rd", mem_rd, 0);
    chk("rwait.mem_wr", mem_wr, 0);
    chk("rwait.addr", mem_addr, 16'h0000);
    chk("rwait.wdata", mem_wdata, 16'h0000);
    chk("rwait.MemOut", MemOut_MEM, 16'h0000);
    chk("rwait.err", mem_err_MEM, 0);
    set_inst(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    rst = 1'b1;
    mem_done = 1'b1;
    #1;
    chk("rwait.late_stall", stall_pipe, 0);
    tick();
    mem_done = 1'b0;
    chk("rwait.late_MemOut", MemOut_MEM, 16'h0000);
    chk("rwait.late_err", mem_err_MEM, 0);

    // Random transactions against a transaction-level model.
    prev_out = 16'h0000;
    for (int t = 0; t < 60; t++) begin
      int          kind, nb, nsel, nlat, tr, st, rds, wrs;
      logic        acc, is_load, merr, s, left, completes;
      logic [15:0] a, w, rdat, p_addr, p_wdata, e_out;
      int          e_st;
      kind = $urandom_range(0, 6);
      nb   = $urandom_range(0, 2);
      nsel = $urandom_range(0, 5);
      nlat = (nsel < 4) ? nsel : ((nsel == 4) ? TO : 99);
      a    = 16'($urandom);
      w    = 16'($urandom);
      rdat = 16'($urandom);
      merr = 1'($urandom_range(0, 1));
      acc     = (kind >= 1 && kind <= 3);
      is_load = (kind == 1 || kind == 3 || kind == 4);
      set_inst(kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 3 || kind >= 5,
               kind == 4, kind == 6, kind == 5, a, w);
      tr = -1; st = 0; rds = 0; wrs = 0; left = 1'b0;
      p_addr = 16'h0000; p_wdata = 16'h0000;
      for (int c = 0; c < 40; c++) begin
        mem_stall = (c < nb);
        mem_done  = (nlat == 0) ? (c == nb) : (tr >= 0 && c == tr + nlat);
        mem_rdata = rdat;
        mem_err   = merr;
        #1;
        if (mem_rd || mem_wr) begin
          tr      = c;
          p_addr  = mem_addr;
          p_wdata = mem_wdata;
        end
        rds += int'(mem_rd);
        wrs += int'(mem_wr);
        s = stall_pipe;
        tick();
        if (!s) begin
          left = 1'b1;
          break;
        end
        st++;
      end
      completes = acc && (nlat < TO);
      e_st  = acc ? nb + ((nlat < TO) ? nlat : TO) : 0;
      e_out = (completes && is_load) ? rdat : prev_out;
      chk($sformatf("r%0d.left", t), left, 1);
      chk($sformatf("r%0d.stall_cycles", t), st, e_st);
      chk($sformatf("r%0d.rd_pulses", t), rds, (acc && is_load) ? 1 : 0);
      chk($sformatf("r%0d.wr_pulses", t), wrs, (acc && !is_load) ? 1 : 0);
      chk($sformatf("r%0d.MemOut", t), MemOut_MEM, e_out);
      chk($sformatf("r%0d.err", t), mem_err_MEM, acc ? (completes ? merr : 1'b1) : 1'b0);
      if (acc) begin
        chk($sformatf("r%0d.req_addr", t), p_addr, a);
        chk($sformatf("r%0d.req_wdata", t), p_wdata, w);
      end
      prev_out = e_out;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
